// File: rtl/ftdi_245fifo_dev_model.sv
// Device-side model of the FT232H 245 synchronous FIFO: drives RXF#/TXE#, honours
// OE#/RD#/WR#, buffers host<->FPGA bytes and flags master handshake violations.
module ftdi_245fifo_dev_model #(
  parameter int unsigned RX_ASIZE = 9,
  parameter int unsigned TX_ASIZE = 9,
  parameter int unsigned PKT_SIZE = 512,
  parameter int unsigned TX_GAP   = 8
) (
  input  logic       usb_clk,
  input  logic       rst_n,
  output logic       usb_rxf,
  output logic       usb_txe,
  input  logic       usb_oe,
  input  logic       usb_rd,
  input  logic       usb_wr,
  input  logic [7:0] usb_data_in,
  output logic [7:0] usb_data_out,
  output logic       usb_data_oe,
  input  logic       h2d_valid,
  output logic       h2d_ready,
  input  logic [7:0] h2d_data,
  output logic       d2h_valid,
  input  logic       d2h_ready,
  output logic [7:0] d2h_data,
  output logic       proto_err
);

  localparam int unsigned RX_DEPTH = 1 << RX_ASIZE;
  localparam int unsigned TX_DEPTH = 1 << TX_ASIZE;
  localparam int unsigned RXC_W    = RX_ASIZE + 1;
  localparam int unsigned TXC_W    = TX_ASIZE + 1;
  localparam int unsigned PKT_W    = 16;
  localparam int unsigned GAP_W    = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  typedef enum logic {BUS_IDLE, BUS_DRIVE} bus_state_e;
  typedef enum logic {PKT_COUNT, PKT_GAP} pkt_state_e;

  logic [7:0]          rx_mem [RX_DEPTH];
  logic [7:0]          tx_mem [TX_DEPTH];

  logic [RX_ASIZE-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RXC_W-1:0]    rx_count_q, rx_count_d;
  logic [TX_ASIZE-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TXC_W-1:0]    tx_count_q, tx_count_d;

  bus_state_e          bus_state_q, bus_state_d;
  pkt_state_e          pkt_state_q, pkt_state_d;
  logic [PKT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                usb_rxf_q, usb_rxf_d;
  logic                usb_txe_q, usb_txe_d;
  logic [7:0]          usb_data_out_q, usb_data_out_d;
  logic                h2d_ready_q, h2d_ready_d;
  logic                d2h_valid_q, d2h_valid_d;
  logic [7:0]          d2h_data_q, d2h_data_d;
  logic                proto_err_q, proto_err_d;

  logic                rx_push_c, rx_pop_c, tx_push_c, tx_pop_c, violation_c;

  // Transfer events seen at the coming edge
  always_comb begin
    rx_push_c   = h2d_valid && h2d_ready_q;
    rx_pop_c    = !usb_rd && !usb_rxf_q && usb_data_oe;
    tx_push_c   = !usb_wr && !usb_txe_q;
    tx_pop_c    = d2h_valid_q && d2h_ready;
    violation_c = (!usb_rd && !usb_data_oe) ||
                  (!usb_wr && usb_data_oe) ||
                  (!usb_rd && !usb_wr);
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    rx_wptr_d  = rx_wptr_q + RX_ASIZE'(rx_push_c);
    rx_rptr_d  = rx_rptr_q + RX_ASIZE'(rx_pop_c);
    rx_count_d = rx_count_q + RXC_W'(rx_push_c) - RXC_W'(rx_pop_c);
    tx_wptr_d  = tx_wptr_q + TX_ASIZE'(tx_push_c);
    tx_rptr_d  = tx_rptr_q + TX_ASIZE'(tx_pop_c);
    tx_count_d = tx_count_q + TXC_W'(tx_push_c) - TXC_W'(tx_pop_c);
  end

  // Storage is not reset; emptiness is tracked by the counts
  always_ff @(posedge usb_clk) begin
    if (rx_push_c) rx_mem[rx_wptr_q] <= h2d_data;
    if (tx_push_c) tx_mem[tx_wptr_q] <= usb_data_in;
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_count_q <= rx_count_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_count_q <= tx_count_d;
    end
  end

  // Bus-drive FSM: state register
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) bus_state_q <= BUS_IDLE;
    else        bus_state_q <= bus_state_d;
  end

  // Bus-drive FSM: next state follows sampled OE#
  always_comb begin
    bus_state_d = bus_state_q;
    if (usb_oe) bus_state_d = BUS_IDLE;
    else        bus_state_d = BUS_DRIVE;
  end

  // Bus-drive FSM: output decode
  always_comb begin
    usb_data_oe = 1'b0;
    if (bus_state_q == BUS_DRIVE) usb_data_oe = 1'b1;
  end

  // Packet FSM: state and counter registers
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state_q <= PKT_COUNT;
      pkt_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      pkt_state_q <= pkt_state_d;
      pkt_cnt_q   <= pkt_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Packet FSM: count USB writes, then hold off writes for TX_GAP cycles
  always_comb begin
    pkt_state_d = pkt_state_q;
    pkt_cnt_d   = pkt_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (pkt_state_q)
      PKT_COUNT: begin
        if (tx_push_c) begin
          if (pkt_cnt_q == PKT_W'(PKT_SIZE - 1)) begin
            pkt_cnt_d = '0;
            if (TX_GAP > 0) begin
              pkt_state_d = PKT_GAP;
              gap_cnt_d   = '0;
            end
          end else begin
            pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
          end
        end
      end
      PKT_GAP: begin
        if (gap_cnt_q == GAP_W'(TX_GAP - 1)) pkt_state_d = PKT_COUNT;
        else                                 gap_cnt_d   = gap_cnt_q + GAP_W'(1);
      end
    endcase
  end

  // Flags and heads computed from next-state values so they are exact one edge later
  always_comb begin
    usb_rxf_d      = (rx_count_d == '0);
    usb_txe_d      = (tx_count_d == TXC_W'(TX_DEPTH)) || (pkt_state_d == PKT_GAP);
    h2d_ready_d    = (rx_count_d != RXC_W'(RX_DEPTH));
    d2h_valid_d    = (tx_count_d != '0);
    proto_err_d    = proto_err_q || violation_c;
    usb_data_out_d = rx_mem[rx_rptr_d];
    if (rx_count_d == '0)                             usb_data_out_d = 8'h00;
    else if (rx_push_c && (rx_wptr_q == rx_rptr_d))   usb_data_out_d = h2d_data;
    d2h_data_d     = tx_mem[tx_rptr_d];
    if (tx_count_d == '0)                             d2h_data_d = 8'h00;
    else if (tx_push_c && (tx_wptr_q == tx_rptr_d))   d2h_data_d = usb_data_in;
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      usb_rxf_q      <= 1'b1;
      usb_txe_q      <= 1'b1;
      usb_data_out_q <= 8'h00;
      h2d_ready_q    <= 1'b1;
      d2h_valid_q    <= 1'b0;
      d2h_data_q     <= 8'h00;
      proto_err_q    <= 1'b0;
    end else begin
      usb_rxf_q      <= usb_rxf_d;
      usb_txe_q      <= usb_txe_d;
      usb_data_out_q <= usb_data_out_d;
      h2d_ready_q    <= h2d_ready_d;
      d2h_valid_q    <= d2h_valid_d;
      d2h_data_q     <= d2h_data_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign usb_rxf      = usb_rxf_q;
  assign usb_txe      = usb_txe_q;
  assign usb_data_out = usb_data_out_q;
  assign h2d_ready    = h2d_ready_q;
  assign d2h_valid    = d2h_valid_q;
  assign d2h_data     = d2h_data_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_ftdi_245fifo_dev_model.sv
// Bench for ftdi_245fifo_dev_model: directed vector table, hand-written corner
// sequences and random legal master traffic checked against a queue-based model.
module tb_ftdi_245fifo_dev_model;

  localparam int unsigned RXA = 2;
  localparam int unsigned TXA = 2;
  localparam int unsigned PKT = 4;
  localparam int unsigned GAP = 3;
  localparam int unsigned RXD = 1 << RXA;
  localparam int unsigned TXD = 1 << TXA;

  logic       usb_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       usb_rxf, usb_txe, usb_data_oe, h2d_ready, d2h_valid, proto_err;
  logic [7:0] usb_data_out, d2h_data;
  logic       usb_oe = 1'b1, usb_rd = 1'b1, usb_wr = 1'b1;
  logic [7:0] usb_data_in = 8'h00, h2d_data = 8'h00;
  logic       h2d_valid = 1'b0, d2h_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 usb_clk = ~usb_clk;

  ftdi_245fifo_dev_model #(
    .RX_ASIZE(RXA), .TX_ASIZE(TXA), .PKT_SIZE(PKT), .TX_GAP(GAP)
  ) dut (
    .usb_clk(usb_clk), .rst_n(rst_n),
    .usb_rxf(usb_rxf), .usb_txe(usb_txe),
    .usb_oe(usb_oe), .usb_rd(usb_rd), .usb_wr(usb_wr),
    .usb_data_in(usb_data_in), .usb_data_out(usb_data_out), .usb_data_oe(usb_data_oe),
    .h2d_valid(h2d_valid), .h2d_ready(h2d_ready), .h2d_data(h2d_data),
    .d2h_valid(d2h_valid), .d2h_ready(d2h_ready), .d2h_data(d2h_data),
    .proto_err(proto_err)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queues plus a gap countdown, stepped on every edge
  logic [7:0] m_rxq[$];
  logic [7:0] m_txq[$];
  int         m_gap  = 0;
  int         m_sent = 0;
  logic       m_rxf = 1'b1, m_txe = 1'b1, m_doe = 1'b0, m_perr = 1'b0;

  initial begin
    logic s_rd, s_wr, s_oe, s_hv, s_dr;
    logic [7:0] s_hd, s_di, e_dout, e_d2h;
    logic rd_pop, wr_push, h_push, d_pop;
    forever begin
      @(posedge usb_clk);
      s_rd = usb_rd; s_wr = usb_wr; s_oe = usb_oe; s_hv = h2d_valid; s_dr = d2h_ready;
      s_hd = h2d_data; s_di = usb_data_in;
      if (!rst_n) begin
        m_rxq.delete(); m_txq.delete();
        m_gap = 0; m_sent = 0;
        m_rxf = 1'b1; m_txe = 1'b1; m_doe = 1'b0; m_perr = 1'b0;
      end else begin
        rd_pop  = !s_rd && !m_rxf && m_doe;
        wr_push = !s_wr && !m_txe;
        h_push  = s_hv && (m_rxq.size() < RXD);
        d_pop   = s_dr && (m_txq.size() > 0);
        if ((!s_rd && !m_doe) || (!s_wr && m_doe) || (!s_rd && !s_wr)) m_perr = 1'b1;
        if (rd_pop) void'(m_rxq.pop_front());
        if (h_push) m_rxq.push_back(s_hd);
        if (d_pop) void'(m_txq.pop_front());
        if (wr_push) m_txq.push_back(s_di);
        if (m_gap > 0) m_gap--;
        else if (wr_push) begin
          m_sent++;
          if (m_sent == PKT) begin
            m_sent = 0;
            m_gap  = GAP;
          end
        end
        m_rxf = (m_rxq.size() == 0);
        m_txe = (m_txq.size() == TXD) || (m_gap > 0);
        m_doe = !s_oe;
      end
      e_dout = (m_rxq.size() > 0) ? m_rxq[0] : 8'h00;
      e_d2h  = (m_txq.size() > 0) ? m_txq[0] : 8'h00;
      #1;
      chk("m.rxf",  16'(usb_rxf),      16'(m_rxf));
      chk("m.txe",  16'(usb_txe),      16'(m_txe));
      chk("m.doe",  16'(usb_data_oe),  16'(m_doe));
      chk("m.dout", 16'(usb_data_out), 16'(e_dout));
      chk("m.hrdy", 16'(h2d_ready),    16'(m_rxq.size() < RXD));
      chk("m.dval", 16'(d2h_valid),    16'(m_txq.size() > 0));
      chk("m.d2h",  16'(d2h_data),     16'(e_d2h));
      chk("m.perr", 16'(proto_err),    16'(m_perr));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge usb_clk);
    #2;
  endtask

  task automatic idle();
    usb_oe = 1'b1; usb_rd = 1'b1; usb_wr = 1'b1; usb_data_in = 8'h00;
    h2d_valid = 1'b0; h2d_data = 8'h00; d2h_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct packed {
    logic hv; logic [7:0] hd; logic oe; logic rd; logic wr; logic [7:0] din; logic dr;
    logic e_rxf; logic [7:0] e_dout; logic e_doe; logic e_hrdy;
    logic e_txe; logic e_dval; logic [7:0] e_d2h; logic e_perr;
  } vec_t;

  vec_t tbl[$];
  int   n_got;

  initial begin
    // USB read: push A5/5A, OE# low, then RD# held low across the empty point
    tbl.push_back('{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    // Packet gap: continuous writes 00..07, d2h always ready
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h06, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h06, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});

    // Reset held with random inputs, then release
    for (int i = 0; i < 4; i++) begin
      usb_oe = 1'($urandom); usb_rd = 1'($urandom); usb_wr = 1'($urandom);
      usb_data_in = 8'($urandom); h2d_valid = 1'($urandom); h2d_data = 8'($urandom);
      d2h_ready = 1'($urandom);
      tick();
      chk("rst.rxf", 16'(usb_rxf), 16'h1);
      chk("rst.txe", 16'(usb_txe), 16'h1);
      chk("rst.doe", 16'(usb_data_oe), 16'h0);
      chk("rst.dout", 16'(usb_data_out), 16'h00);
      chk("rst.hrdy", 16'(h2d_ready), 16'h1);
      chk("rst.dval", 16'(d2h_valid), 16'h0);
      chk("rst.d2h", 16'(d2h_data), 16'h00);
      chk("rst.perr", 16'(proto_err), 16'h0);
    end
    idle();
    rst_n = 1'b1;
    tick();
    chk("rel.txe", 16'(usb_txe), 16'h0);
    chk("rel.rxf", 16'(usb_rxf), 16'h1);

    // Table-driven USB read and packet-gap vectors
    for (int i = 0; i < tbl.size(); i++) begin
      h2d_valid = tbl[i].hv; h2d_data = tbl[i].hd; usb_oe = tbl[i].oe; usb_rd = tbl[i].rd;
      usb_wr = tbl[i].wr; usb_data_in = tbl[i].din; d2h_ready = tbl[i].dr;
      tick();
      chk($sformatf("vec%0d.rxf", i),  16'(usb_rxf),      16'(tbl[i].e_rxf));
      chk($sformatf("vec%0d.dout", i), 16'(usb_data_out), 16'(tbl[i].e_dout));
      chk($sformatf("vec%0d.doe", i),  16'(usb_data_oe),  16'(tbl[i].e_doe));
      chk($sformatf("vec%0d.hrdy", i), 16'(h2d_ready),    16'(tbl[i].e_hrdy));
      chk($sformatf("vec%0d.txe", i),  16'(usb_txe),      16'(tbl[i].e_txe));
      chk($sformatf("vec%0d.dval", i), 16'(d2h_valid),    16'(tbl[i].e_dval));
      chk($sformatf("vec%0d.d2h", i),  16'(d2h_data),     16'(tbl[i].e_d2h));
      chk($sformatf("vec%0d.perr", i), 16'(proto_err),    16'(tbl[i].e_perr));
    end

    // RX full: fifth push waits for a USB pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      h2d_valid = 1'b1; h2d_data = 8'(8'hB0 + i);
      tick();
    end
    chk("rxfull.hrdy", 16'(h2d_ready), 16'h0);
    chk("rxfull.dout", 16'(usb_data_out), 16'hB0);
    h2d_data = 8'hB4;
    repeat (2) tick();
    chk("rxfull.refuse", 16'(h2d_ready), 16'h0);
    usb_oe = 1'b0;
    tick();
    chk("rxfull.doe", 16'(usb_data_oe), 16'h1);
    usb_rd = 1'b0;
    tick();
    chk("rxfull.rdy_after_pop", 16'(h2d_ready), 16'h1);
    chk("rxfull.dout_b1", 16'(usb_data_out), 16'hB1);
    usb_rd = 1'b1;
    tick();
    chk("rxfull.fifth_in", 16'(h2d_ready), 16'h0);
    h2d_valid = 1'b0;
    usb_rd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rxfull.drain%0d", k), 16'(usb_data_out), 16'(8'hB1 + k));
      tick();
    end
    chk("rxfull.empty_rxf", 16'(usb_rxf), 16'h1);
    chk("rxfull.empty_dout", 16'(usb_data_out), 16'h00);
    idle();
    tick();

    // TX full: six write attempts with d2h stalled, exactly four land
    do_reset();
    for (int i = 0; i < 6; i++) begin
      usb_wr = 1'b0; usb_data_in = 8'(8'h10 + i);
      tick();
    end
    usb_wr = 1'b1;
    repeat (5) tick();
    chk("txfull.txe_high", 16'(usb_txe), 16'h1);
    chk("txfull.head", 16'(d2h_data), 16'h10);
    d2h_ready = 1'b1;
    tick();
    chk("txfull.txe_low", 16'(usb_txe), 16'h0);
    n_got = 1;
    for (int g = 0; g < 8 && d2h_valid; g++) begin
      chk($sformatf("txfull.byte%0d", n_got), 16'(d2h_data), 16'(8'h10 + n_got));
      n_got++;
      tick();
    end
    chk("txfull.accepted", 16'(n_got), 16'd4);
    idle();

    // Protocol errors: RD# without OE#, then WR# during bus drive
    do_reset();
    usb_rd = 1'b0;
    tick();
    chk("perr.rd_no_oe", 16'(proto_err), 16'h1);
    usb_rd = 1'b1;
    repeat (3) tick();
    chk("perr.sticky", 16'(proto_err), 16'h1);
    do_reset();
    chk("perr.cleared", 16'(proto_err), 16'h0);
    usb_oe = 1'b0;
    tick();
    usb_wr = 1'b0;
    tick();
    chk("perr.wr_drive", 16'(proto_err), 16'h1);
    idle();
    tick();

    // Random legal master and host traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      h2d_valid   = 1'($urandom_range(0, 1));
      h2d_data    = 8'($urandom);
      d2h_ready   = ($urandom_range(0, 3) != 0);
      usb_data_in = 8'($urandom);
      if ($urandom_range(0, 5) == 0) usb_oe = ~usb_oe;
      usb_rd = 1'b1;
      usb_wr = 1'b1;
      if (m_doe) usb_rd = 1'($urandom_range(0, 1));
      else       usb_wr = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rand.perr", 16'(proto_err), 16'h0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ftdi_245fifo_dev_model.md
# ftdi_245fifo_dev_model

Synthesizable device-side model of the FT232H 245 synchronous FIFO interface: the responder that `ftdi_245fifo` talks to. It drives RXF#/TXE#, honours OE#/RD#/WR#, and buffers bytes in two internal FIFOs. A host-side byte stream feeds bytes for the FPGA to read, and bytes the FPGA writes are delivered to a host-side sink. It sits in loopback benches and on-board self-test builds in place of the physical chip. A sticky protocol-error flag catches master-side handshake violations.

## Interface
- `RX_ASIZE`, 9: log2 depth of the host→FPGA (RX) FIFO.
- `TX_ASIZE`, 9: log2 depth of the FPGA→host (TX) FIFO.
- `PKT_SIZE`, 512: bytes accepted on the USB side before a forced TXE# gap (emulates USB packet flush); range 1..65535.
- `TX_GAP`, 8: cycles TXE# is held high after each packet; 0 disables gaps.
- `usb_clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `usb_rxf` out 1: RXF#; low means the RX FIFO holds data.
- `usb_txe` out 1: TXE#; low means the TX FIFO can accept a byte.
- `usb_oe` in 1: OE# from the master.
- `usb_rd` in 1: RD# from the master.
- `usb_wr` in 1: WR# from the master.
- `usb_data_in` in 8: bus value driven by the master.
- `usb_data_out` out 8: bus value driven by this model.
- `usb_data_oe` out 1: model drives the bus; the wrapper builds the tristate from this.
- `h2d_valid` in 1, `h2d_ready` out 1, `h2d_data` in 8: host push port into the RX FIFO.
- `d2h_valid` out 1, `d2h_ready` in 1, `d2h_data` out 8: host pop port from the TX FIFO.
- `proto_err` out 1: sticky master-side protocol violation.

## Operation
- **RX FIFO**
  - Host push when `h2d_valid && h2d_ready`.
  - `h2d_ready = !rx_full`. A push is refused on a full FIFO even if a USB pop occurs in the same cycle.
- **USB read**
  - Pop occurs at an edge where `usb_rd==0 && usb_rxf==0 && usb_data_oe==1`.
  - `usb_data_out` = RX FIFO head (first-word fall-through); 8'h00 when empty.
- **Bus-drive state machine**
  - BUS_IDLE → BUS_DRIVE when `usb_oe==0` is sampled.
  - BUS_DRIVE → BUS_IDLE when `usb_oe==1` is sampled.
  - `usb_data_oe` = 1 only in BUS_DRIVE (registered, so there is one cycle of turnaround after OE# falls).
- **TX FIFO**
  - Push of `usb_data_in` occurs at an edge where `usb_wr==0 && usb_txe==0`.
  - `d2h_valid = !tx_empty`, `d2h_data` = head; pop when `d2h_valid && d2h_ready`.
- **Packet state machine**
  - COUNT: 16-bit `pkt_cnt` increments per USB write. At the write that makes `pkt_cnt==PKT_SIZE`, clear `pkt_cnt` and go to GAP if `TX_GAP>0`.
  - GAP: `gap_cnt` counts `TX_GAP` cycles, then returns to COUNT. No writes are accepted while in GAP.
- **Flag registers**
  - `usb_rxf <= (rx_count_next==0)`.
  - `usb_txe <= tx_full_next || (pkt_state_next==GAP)`.
  - Both are computed from next-state values, so a master that obeys the flags can never overflow or underflow.
- **`proto_err`** is set, and stays set until reset, when any of the following is sampled:
  - `usb_rd==0` while `usb_data_oe==0`;
  - `usb_wr==0` while `usb_data_oe==1` (bus contention);
  - `usb_rd==0 && usb_wr==0`.
  - RD# low with RXF# high is legal and is ignored.
- **Counts** are `ASIZE+1` bits; pointers wrap modulo depth.
  - Full: count == 2^ASIZE.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.

## Timing
- **Reset values**
  - `usb_rxf=1`, `usb_txe=1`, `usb_data_oe=0`, `usb_data_out=8'h00`, `h2d_ready=1`, `d2h_valid=0`, `d2h_data=8'h00`, `proto_err=0`.
  - FIFOs empty, `pkt_cnt=0`, packet state COUNT, bus state BUS_IDLE.
  - Reset asserted mid-transfer discards all FIFO contents immediately.
- **After reset release:** `usb_txe` falls at the first rising edge.
- **Host push to RXF#:** a byte pushed at edge N makes `usb_rxf` low after edge N. The FPGA may read it at edge N+1 (with OE# already established).
- **OE# to bus drive:** OE# sampled low at edge N asserts `usb_data_oe` after edge N. The earliest pop is at edge N+1.
- **Last RX byte:** a pop of the last byte at edge N raises `usb_rxf` after edge N, so a back-to-back read at N+1 is not a pop.
- **Last TX slot or packet end:** a write filling the last slot, or completing a packet, at edge N raises `usb_txe` after edge N.
- **GAP:** lasts exactly `TX_GAP` cycles with `usb_txe` high. If the FIFO is still full at the end of GAP, `usb_txe` stays high.
- **Throughput:** one byte per cycle in each direction.

## Test plan
- **Reset:** hold `rst_n=0` with random inputs → all outputs at reset values. Release → `usb_txe=0` one edge later, `usb_rxf=1`.
- **USB read:** host pushes 8'hA5, 8'h5A. Master drops OE#, then RD# one cycle later and holds it low → bytes A5 and 5A are popped on consecutive edges, `usb_rxf` rises after the second pop, and no third pop occurs.
- **RX full:** with `RX_ASIZE=2`, the host pushes 5 bytes → `h2d_ready=0` after the 4th. The 5th is accepted only after a USB pop.
- **Packet gap:** with `PKT_SIZE=4`, `TX_GAP=3`, master writes 0x00..0x07 continuously → `usb_txe` is high for exactly 3 cycles after the 4th byte. `d2h` delivers 00..07 in order.
- **TX full:** with `TX_ASIZE=2`, `d2h_ready=0`, 6 writes attempted → exactly 4 accepted and `usb_txe` stays high. One `d2h` pop → `usb_txe` low after the next edge.
- **Protocol error:** assert RD# low without prior OE# → `proto_err=1` after that edge and held until reset. Separately, assert WR# low during BUS_DRIVE → `proto_err=1`.
